// File: rtl/tomasulo_pkg.sv
// Shared constants for the Tomasulo core: opcodes, ROB geometry, data width
// and the indices of the functional units that complete onto the CDB.
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int DATA_W    = 16;
  localparam int NUM_FU    = 3;
  localparam int SRC_W     = 2;

  localparam int ADD_FU = 0;
  localparam int MUL_FU = 1;
  localparam int LD_FU  = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_LD  = 3'd4,
    OP_ST  = 3'd5,
    OP_BEQ = 3'd6,
    OP_NOP = 3'd7
  } opcode_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [SRC_W-1:0]  src;
  } cdb_bcast_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: grants the first asserted request found when
// scanning upward from rr_ptr, wrapping modulo NREQ. Purely combinational.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            found
);

  int w_cand;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    w_cand = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = int'(rr_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      if (!found && req[w_cand]) begin
        found       = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = PW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among completing units, one
// registered broadcast per granted cycle, plus a wrapping broadcast counter.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NREQ = NUM_FU,
  parameter int DW   = DATA_W,
  parameter int TW   = TAG_W
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*TW-1:0] req_tag,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               cdb_en,
  input  logic               flush,
  output logic [NREQ-1:0]    gnt,
  output logic               cdb_valid,
  output logic [TW-1:0]      cdb_tag,
  output logic [DW-1:0]      cdb_data,
  output logic [SRC_W-1:0]   cdb_src,
  output logic [7:0]         bcast_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    r_rr_ptr;
  logic             r_cdb_valid;
  logic [TW-1:0]    r_cdb_tag;
  logic [DW-1:0]    r_cdb_data;
  logic [SRC_W-1:0] r_cdb_src;
  logic [7:0]       r_bcast_cnt;

  logic [NREQ-1:0]  w_pick_gnt;
  logic [PW-1:0]    w_pick_idx;
  logic             w_pick_found;
  logic             w_grant;
  logic [PW-1:0]    w_ptr_next;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .gnt    (w_pick_gnt),
    .idx    (w_pick_idx),
    .found  (w_pick_found)
  );

  // Reset, flush and a busy ROB write port all veto the grant in the same cycle.
  assign w_grant    = rst_n & cdb_en & ~flush & w_pick_found;
  assign gnt        = w_grant ? w_pick_gnt : '0;
  assign w_ptr_next = (int'(w_pick_idx) == NREQ - 1) ? '0 : w_pick_idx + 1'b1;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= '0;
      r_bcast_cnt <= '0;
    end else begin
      r_cdb_valid <= w_grant;
      if (w_grant) begin
        r_rr_ptr    <= w_ptr_next;
        r_cdb_tag   <= req_tag[int'(w_pick_idx)*TW +: TW];
        r_cdb_data  <= req_data[int'(w_pick_idx)*DW +: DW];
        r_cdb_src   <= SRC_W'(w_pick_idx);
        r_bcast_cnt <= r_bcast_cnt + 8'd1;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;
  assign bcast_cnt = r_bcast_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grant order, latency, backpressure, flush,
// reset mid-stream and broadcast-counter wrap, checked with immediate asserts.
module tb_cdb_arbiter;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [8:0] req_tag;
  logic [47:0] req_data;
  logic       cdb_en;
  logic       flush;
  logic [2:0] gnt;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic [15:0] cdb_data;
  logic [1:0] cdb_src;
  logic [7:0] bcast_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  cdb_arbiter dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .req       (req),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .cdb_en    (cdb_en),
    .flush     (flush),
    .gnt       (gnt),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src),
    .bcast_cnt (bcast_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk_bcast(input string tag, input logic [2:0] t, input logic [15:0] d,
                           input logic [1:0] s, input logic [7:0] c);
    chk({tag, ".valid"}, 32'(cdb_valid), 32'd1);
    chk({tag, ".tag"},   32'(cdb_tag),   32'(t));
    chk({tag, ".data"},  32'(cdb_data),  32'(d));
    chk({tag, ".src"},   32'(cdb_src),   32'(s));
    chk({tag, ".cnt"},   32'(bcast_cnt), 32'(c));
  endtask

  initial begin
    logic [2:0] exp_gnt [3];
    exp_gnt[0] = 3'b001;
    exp_gnt[1] = 3'b010;
    exp_gnt[2] = 3'b100;

    // Reset with requests pending: no grant may leak out.
    rst_n = 1'b0; req = 3'b111; req_tag = '0; req_data = '0; cdb_en = 1'b1; flush = 1'b0;
    tick(); tick();
    #1;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.valid", 32'(cdb_valid), 32'd0);
    chk("rst.tag", 32'(cdb_tag), 32'd0);
    chk("rst.data", 32'(cdb_data), 32'd0);
    chk("rst.src", 32'(cdb_src), 32'd0);
    chk("rst.cnt", 32'(bcast_cnt), 32'd0);
    $display("reset: valid=%0d cnt=%0d", cdb_valid, bcast_cnt);
    tick();
    rst_n = 1'b1; req = 3'b000;

    // Single requester 1.
    req = 3'b010; req_tag[3 +: 3] = 3'd5; req_data[16 +: 16] = 16'h00A3;
    #1 chk("single.gnt", 32'(gnt), 32'b010);
    tick(); req = 3'b000;
    chk_bcast("single", 3'd5, 16'h00A3, 2'd1, 8'd1);
    $display("single: src=%0d tag=%0d data=%h cnt=%0d", cdb_src, cdb_tag, cdb_data, bcast_cnt);
    tick();
    chk("idle.valid", 32'(cdb_valid), 32'd0);
    chk("idle.tag_hold", 32'(cdb_tag), 32'd5);
    chk("idle.data_hold", 32'(cdb_data), 32'h00A3);
    chk("idle.src_hold", 32'(cdb_src), 32'd1);
    $display("idle: valid=%0d tag=%0d", cdb_valid, cdb_tag);

    // Re-reset so the round-robin pointer starts at 0.
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // All requesting: order 0,1,2.
    req = 3'b111;
    req_tag = {3'd3, 3'd2, 3'd1};
    req_data = {16'h0033, 16'h0022, 16'h0011};
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("rr%0d.gnt", i), 32'(gnt), 32'(exp_gnt[i]));
      tick();
      req = req & ~exp_gnt[i];
      chk_bcast($sformatf("rr%0d", i), 3'(i + 1), 16'(17 * (i + 1)), 2'(i), 8'(i + 1));
      $display("rr: grant %0d src=%0d tag=%0d data=%h", i, cdb_src, cdb_tag, cdb_data);
    end

    // Backpressure for 4 cycles, then requester 0 first.
    req = 3'b111; cdb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("bp%0d.gnt", i), 32'(gnt), 32'd0);
      tick();
      chk($sformatf("bp%0d.valid", i), 32'(cdb_valid), 32'd0);
      $display("backpressure cycle %0d: valid=%0d", i, cdb_valid);
    end
    cdb_en = 1'b1;
    #1 chk("bp.release_gnt", 32'(gnt), 32'b001);
    tick(); req = 3'b110;
    chk_bcast("bp.release", 3'd1, 16'h0011, 2'd0, 8'd4);
    $display("backpressure release: src=%0d cnt=%0d", cdb_src, bcast_cnt);

    // Flush with rr_ptr=1, req=110.
    flush = 1'b1;
    #1 chk("flush.gnt", 32'(gnt), 32'd0);
    tick(); flush = 1'b0;
    chk("flush.valid", 32'(cdb_valid), 32'd0);
    chk("flush.cnt", 32'(bcast_cnt), 32'd4);
    #1 chk("flush.ptr_held_gnt", 32'(gnt), 32'b010);
    tick(); req = 3'b100;
    chk_bcast("flush.after", 3'd2, 16'h0022, 2'd1, 8'd5);
    $display("flush: post-flush src=%0d cnt=%0d", cdb_src, bcast_cnt);

    // Flush together with cdb_en=0.
    flush = 1'b1; cdb_en = 1'b0;
    #1 chk("flushbp.gnt", 32'(gnt), 32'd0);
    tick(); flush = 1'b0; cdb_en = 1'b1;
    chk("flushbp.valid", 32'(cdb_valid), 32'd0);
    #1 chk("flushbp.after_gnt", 32'(gnt), 32'b100);
    tick(); req = 3'b000;
    chk_bcast("flushbp.after", 3'd3, 16'h0033, 2'd2, 8'd6);
    $display("flush+bp: src=%0d cnt=%0d", cdb_src, bcast_cnt);

    // Reset mid-stream after two grants.
    req = 3'b111;
    #1 chk("mid.g0", 32'(gnt), 32'b001);
    tick(); req = 3'b110;
    #1 chk("mid.g1", 32'(gnt), 32'b010);
    tick(); req = 3'b111; rst_n = 1'b0;
    chk("mid.pre_cnt", 32'(bcast_cnt), 32'd8);
    #1 chk("mid.rst_gnt", 32'(gnt), 32'd0);
    tick(); rst_n = 1'b1;
    chk("mid.valid", 32'(cdb_valid), 32'd0);
    chk("mid.cnt", 32'(bcast_cnt), 32'd0);
    chk("mid.src", 32'(cdb_src), 32'd0);
    #1 chk("mid.first_gnt", 32'(gnt), 32'b001);
    tick();
    chk_bcast("mid.first", 3'd1, 16'h0011, 2'd0, 8'd1);
    $display("mid-stream reset: first src=%0d cnt=%0d", cdb_src, bcast_cnt);

    // Counter wrap: requester 0 presents a new result every cycle.
    req = 3'b001;
    for (int i = 0; i < 255; i++) begin
      req_data[0 +: 16] = 16'(i);
      tick();
      chk($sformatf("wrap%0d.valid", i), 32'(cdb_valid), 32'd1);
      chk($sformatf("wrap%0d.data", i), 32'(cdb_data), 32'(i));
      chk($sformatf("wrap%0d.cnt", i), 32'(bcast_cnt), 32'((i + 2) % 256));
    end
    $display("wrap: cnt=%0d valid=%0d", bcast_cnt, cdb_valid);
    req = 3'b000;
    tick();
    chk("wrap.end_valid", 32'(cdb_valid), 32'd0);
    chk("wrap.end_cnt", 32'(bcast_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
